// File: rtl/addition_aligner.sv
// Pre-add exponent alignment: right-shifts the smaller-exponent mantissa by the
// exponent difference, SHIFT_STEP bits per cycle, collecting guard and sticky bits.
module addition_aligner #(
  parameter int MW         = 24,
  parameter int GUARD      = 2,
  parameter int SHIFT_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          a_e,
  input  logic [MW-1:0]       a_m,
  input  logic [7:0]          b_e,
  input  logic [MW-1:0]       b_m,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          output_e,
  output logic [MW+GUARD-1:0] out_ml,
  output logic [MW+GUARD-1:0] out_ms,
  output logic                out_sticky,
  output logic                out_swap
);

  localparam int W = MW + GUARD;
  localparam logic [7:0] STEP8 = 8'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     rem_q, rem_d;
  logic [7:0]     exp_q, exp_d;
  logic [W-1:0]   ml_q, ml_d;
  logic [W-1:0]   ms_q, ms_d;
  logic           sticky_q, sticky_d;
  logic           swap_q, swap_d;

  logic           swap_in;
  logic [7:0]     le, se, diff, k;
  logic [MW-1:0]  lm, sm;
  logic [W-1:0]   drop_mask;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign output_e   = exp_q;
  assign out_ml     = ml_q;
  assign out_ms     = ms_q;
  assign out_sticky = sticky_q;
  assign out_swap   = swap_q;

  always_comb begin
    swap_in = (b_e > a_e);
    le      = swap_in ? b_e : a_e;
    se      = swap_in ? a_e : b_e;
    lm      = swap_in ? b_m : a_m;
    sm      = swap_in ? a_m : b_m;
    diff    = le - se;
  end

  // Per-cycle step is clamped to the remaining distance; drop_mask selects the bits leaving the LSB.
  always_comb begin
    k         = (rem_q < STEP8) ? rem_q : STEP8;
    drop_mask = ~({W{1'b1}} << k);
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    exp_d    = exp_q;
    ml_d     = ml_q;
    ms_d     = ms_q;
    sticky_d = sticky_q;
    swap_d   = swap_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d    = le;
          ml_d     = {lm, {GUARD{1'b0}}};
          ms_d     = {sm, {GUARD{1'b0}}};
          sticky_d = 1'b0;
          swap_d   = swap_in;
          rem_d    = diff;
          if (diff == '0) begin
            state_d = DONE;
          end else if (int'(diff) >= W) begin
            ms_d     = '0;
            sticky_d = |sm;
            rem_d    = '0;
            state_d  = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sticky_d = sticky_q | (|(ms_q & drop_mask));
        ms_d     = ms_q >> k;
        rem_d    = rem_q - k;
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      exp_q    <= '0;
      ml_q     <= '0;
      ms_q     <= '0;
      sticky_q <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      exp_q    <= exp_d;
      ml_q     <= ml_d;
      ms_q     <= ms_d;
      sticky_q <= sticky_d;
      swap_q   <= swap_d;
    end
  end

endmodule
